block_assembler: RTL

Parametrised successor to the byte-wise block builder. It packs a stream of IN_BYTES-wide words into BLOCK_BYTES-wide blocks for the AES datapath, with valid/ready handshakes on both sides. It holds one completed block in an output register, so the producer keeps filling while downstream stalls. A flush request closes a partial block and reports how many real bytes it holds.

---
 rtl/block_assembler_if.sv | 22 ++
 rtl/block_assembler.sv | 61 ++++++
 2 files changed

// File: rtl/block_assembler_if.sv
// block_assembler_if: producer/consumer handshake bundle for block_assembler
interface block_assembler_if #(
  parameter int IN_BYTES = 1,
  parameter int BLOCK_BYTES = 16
);
  logic [IN_BYTES*8-1:0] data_in;
  logic data_valid_in;
  logic data_ready_out;
  logic flush_in;
  logic [BLOCK_BYTES*8-1:0] block_out;
  logic [$clog2(BLOCK_BYTES):0] len_out;
  logic valid_out;
  logic ready_in;
  modport master (
    output data_in, data_valid_in, flush_in, ready_in,
    input data_ready_out, block_out, len_out, valid_out
  );
  modport slave (
    input data_in, data_valid_in, flush_in, ready_in,
    output data_ready_out, block_out, len_out, valid_out
  );
endinterface

// File: rtl/block_assembler.sv
// block_assembler: packs IN_BYTES words into BLOCK_BYTES blocks with flush; define BLOCK_ASSEMBLER_PKCS7_EN for PKCS#7 padding and empty-flush pad blocks
module block_assembler #(
  parameter int IN_BYTES = 1,
  parameter int BLOCK_BYTES = 16
) (
  input logic clk_in,
  input logic rst_n_in,
  block_assembler_if.slave bus
);
  localparam int WORDS = BLOCK_BYTES / IN_BYTES;
  localparam int WW = $clog2(WORDS + 1);
  localparam int LW = $clog2(BLOCK_BYTES) + 1;
  logic [BLOCK_BYTES*8-1:0] col, col_n, blk_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [LW-1:0] len_n;
  logic [7:0] pad;
  logic fp, fp_n, free, acc, full, xfer, keep_fp;
  assign bus.data_ready_out = wcnt != WW'(WORDS) && !fp;
  always_comb begin
    acc = bus.data_valid_in && bus.data_ready_out;
    free = !bus.valid_out || bus.ready_in;
    wcnt_n = wcnt + WW'(acc);
    fp_n = fp || bus.flush_in;
    full = wcnt_n == WW'(WORDS);
    len_n = LW'(int'(wcnt_n) * IN_BYTES);
`ifdef BLOCK_ASSEMBLER_PKCS7_EN
    pad = 8'(BLOCK_BYTES - int'(len_n));
    xfer = free && (full || fp_n);
    keep_fp = fp_n && !xfer;
`else
    pad = 8'h00;
    xfer = free && (full || (fp_n && wcnt_n != '0));
    keep_fp = fp_n && !xfer && wcnt_n != '0;
`endif
    col_n = col;
    blk_n = '0;
    for (int w = 0; w < WORDS; w++)
      col_n[w*IN_BYTES*8 +: IN_BYTES*8] = acc && int'(wcnt) == w ? bus.data_in : col[w*IN_BYTES*8 +: IN_BYTES*8];
    for (int i = 0; i < BLOCK_BYTES; i++)
      blk_n[i*8 +: 8] = i < int'(len_n) ? col_n[i*8 +: 8] : pad;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      col <= '0;
      wcnt <= '0;
      fp <= 1'b0;
      bus.block_out <= '0;
      bus.len_out <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      col <= col_n;
      wcnt <= xfer ? '0 : wcnt_n;
      fp <= keep_fp;
      bus.valid_out <= xfer || (bus.valid_out && !bus.ready_in);
      if (xfer) begin
        bus.block_out <= blk_n;
        bus.len_out <= len_n;
      end
    end
  end
endmodule
